// File: rtl/sram_controller_pkg.sv
// Shared definitions for the processor memory stage: SRAM geometry, the data
// segment base address and the controller state encoding.
package sram_controller_pkg;

   localparam int unsigned SRAM_ADDR_W    = 18;
   localparam int unsigned SRAM_DATA_W    = 16;
   localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2,
      S_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/sram_controller.sv
// Memory-stage SRAM controller: splits each 32-bit load/store into two 16-bit
// SRAM accesses and freezes the pipeline through ready until the word is done.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR     = SRAM_BASE_ADDR
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wrEn,
   input  logic                   rdEn,
   input  logic [31:0]            address,
   input  logic [31:0]            writeData,
   output logic [31:0]            readData,
   output logic                   ready,
   inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N
);

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   wr_q, wr_d;
   logic [31:0]            rdata_q, rdata_d;

   logic                   req;
   logic                   last;
   logic [31:0]            phys;
   logic [16:0]            word;
   logic                   dq_oe;
   logic [SRAM_DATA_W-1:0] dq_out;
   logic                   unused_phys;

   assign req  = rdEn | wrEn;
   assign last = (cnt_q == LAST_CNT);

   // Byte address relative to the data segment; out-of-range bits simply wrap.
   assign phys        = address - BASE_ADDR;
   assign word        = phys[18:2];
   assign unused_phys = ^{phys[31:19], phys[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      rdata_d = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            // Write wins when both strobes are up; the op is latched for the access.
            if (req) begin
               state_d = S_LOW;
               wr_d    = wrEn;
            end
         end
         S_LOW: begin
            if (last) begin
               state_d = S_HIGH;
               if (!wr_q) rdata_d[15:0] = SRAM_DQ;
            end
         end
         S_HIGH: begin
            if (last) begin
               state_d = S_DONE;
               if (!wr_q) rdata_d[31:16] = SRAM_DQ;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q)
         cnt_d = '0;
      else if (state_q == S_LOW || state_q == S_HIGH)
         cnt_d = cnt_q + 4'd1;
      else
         cnt_d = '0;
   end

   always_comb begin
      ready     = 1'b0;
      SRAM_ADDR = '0;
      SRAM_WE_N = 1'b1;
      dq_oe     = 1'b0;
      dq_out    = '0;
      unique case (state_q)
         S_IDLE: ready = ~req;
         S_LOW: begin
            SRAM_ADDR = {word, 1'b0};
            SRAM_WE_N = ~wr_q;
            dq_oe     = wr_q;
            dq_out    = writeData[15:0];
         end
         S_HIGH: begin
            SRAM_ADDR = {word, 1'b1};
            SRAM_WE_N = ~wr_q;
            dq_oe     = wr_q;
            dq_out    = writeData[31:16];
         end
         S_DONE:  ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};
   assign readData  = rdata_q;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller against a behavioural 256K x 16 SRAM.
module sram_model (
   input  logic        clk,
   input  logic [17:0] addr,
   input  logic        we_n,
   inout  wire  [15:0] dq
);
   logic [15:0] mem [0:262143];

   assign dq = we_n ? mem[addr] : 16'hzzzz;

   always @(posedge clk) begin
      if (!we_n) mem[addr] <= dq;
   end
endmodule

module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        wrEn;
   logic        rdEn;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        ready;
   wire  [15:0] SRAM_DQ;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_WE_N;
   logic        SRAM_UB_N;
   logic        SRAM_LB_N;
   logic        SRAM_CE_N;
   logic        SRAM_OE_N;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_controller #(.ACCESS_CYCLES(2), .BASE_ADDR(32'd1024)) dut (
      .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn),
      .address(address), .writeData(writeData),
      .readData(readData), .ready(ready),
      .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
   );

   sram_model u_mem (.clk(clk), .addr(SRAM_ADDR), .we_n(SRAM_WE_N), .dq(SRAM_DQ));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
   task automatic do_access(input string name, input logic wr, input logic rd,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic keep, output logic [31:0] rdout);
      logic [31:0] phys;
      logic [16:0] w;
      logic [15:0] half;
      phys      = addr - 32'd1024;
      w         = phys[18:2];
      wrEn      = wr;
      rdEn      = rd;
      address   = addr;
      writeData = wd;
      #1;
      chk({name, "_ready_T"}, {31'h0, ready}, 32'h0);
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         #2;
         if (c < 5) begin
            chk($sformatf("%s_ready_T%0d", name, c), {31'h0, ready}, 32'h0);
            chk($sformatf("%s_addr_T%0d", name, c), {14'h0, SRAM_ADDR},
                {14'h0, w, (c > 2) ? 1'b1 : 1'b0});
            chk($sformatf("%s_wen_T%0d", name, c), {31'h0, SRAM_WE_N}, {31'h0, ~wr});
            if (wr) begin
               half = (c > 2) ? wd[31:16] : wd[15:0];
               chk($sformatf("%s_dq_T%0d", name, c), {16'h0, SRAM_DQ}, {16'h0, half});
            end
         end else begin
            chk({name, "_ready_done"}, {31'h0, ready}, 32'h1);
            chk({name, "_addr_done"}, {14'h0, SRAM_ADDR}, 32'h0);
            chk({name, "_wen_done"}, {31'h0, SRAM_WE_N}, 32'h1);
         end
      end
      rdout = readData;
      if (!keep) begin
         wrEn = 1'b0;
         rdEn = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   logic [31:0] rd;

   initial begin
      rst = 1'b1; wrEn = 1'b0; rdEn = 1'b0; address = '0; writeData = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'h0, ready}, 32'h1);
      chk("rst_rdata", readData, 32'h0);
      chk("rst_wen", {31'h0, SRAM_WE_N}, 32'h1);
      chk("rst_addr", {14'h0, SRAM_ADDR}, 32'h0);
      chk("rst_ties", {28'h0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 32'h0);
      chk("rst_dq_z", {16'h0, SRAM_DQ}, {16'h0, u_mem.mem[0]});
      rst = 1'b0;
      @(posedge clk);
      #1;

      do_access("wr1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0, rd);
      chk("mem0", {16'h0, u_mem.mem[0]}, 32'h0000BEEF);
      chk("mem1", {16'h0, u_mem.mem[1]}, 32'h0000DEAD);
      chk("wr_keeps_rdata", readData, 32'h0);

      do_access("rd1024", 1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, rd);
      chk("rd1024_data", rd, 32'hDEADBEEF);

      do_access("wr1028", 1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0, rd);
      chk("mem2", {16'h0, u_mem.mem[2]}, 32'h00005678);
      chk("mem3", {16'h0, u_mem.mem[3]}, 32'h00001234);
      chk("wr1028_rdata_hold", readData, 32'hDEADBEEF);

      // Request held through DONE starts a second, independent access.
      do_access("rdA", 1'b0, 1'b1, 32'd1024, 32'h0, 1'b1, rd);
      chk("rdA_data", rd, 32'hDEADBEEF);
      do_access("rdB", 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, rd);
      chk("rdB_data", rd, 32'h12345678);

      do_access("rdwr1032", 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 1'b0, rd);
      chk("rdwr_rdata", rd, 32'h12345678);
      chk("mem4", {16'h0, u_mem.mem[4]}, 32'h0000A5A5);
      chk("mem5", {16'h0, u_mem.mem[5]}, 32'h0000A5A5);

      // Reset during the HIGH half of a read.
      rdEn = 1'b1; address = 32'd1028;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_in_high", {14'h0, SRAM_ADDR}, 32'h3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; rdEn = 1'b0;
      #1;
      chk("abort_rdata", readData, 32'h0);
      chk("abort_wen", {31'h0, SRAM_WE_N}, 32'h1);
      chk("abort_addr", {14'h0, SRAM_ADDR}, 32'h0);
      chk("abort_idle", {31'h0, ready}, 32'h1);
      @(posedge clk);
      #1;
      do_access("rd_after_rst", 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, rd);
      chk("rd_after_rst_data", rd, 32'h12345678);

      do_access("wr1020", 1'b1, 1'b0, 32'd1020, 32'h0BADF00D, 1'b0, rd);
      chk("mem_wrap_lo", {16'h0, u_mem.mem[18'h3FFFE]}, 32'h0000F00D);
      chk("mem_wrap_hi", {16'h0, u_mem.mem[18'h3FFFF]}, 32'h00000BAD);
      do_access("rd1020", 1'b0, 1'b1, 32'd1020, 32'h0, 1'b0, rd);
      chk("rd1020_data", rd, 32'h0BADF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
